// File: rtl/egress_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : egress_arbiter_pkg                                     |
// | Description : Shared types and constants for the D0/D1 egress        |
// |               arbiter (FSM encoding, source tags, default width).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package egress_arbiter_pkg;

  localparam int DEFAULT_BW = 6;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SERVE_D0 = 2'd1,
    ST_SERVE_D1 = 2'd2
  } arb_state_t;

  // A programmed weight of zero still grants one word per turn.
  function automatic logic [3:0] eff_weight(input logic [3:0] peso);
    return (peso == 4'd0) ? 4'd1 : peso;
  endfunction

endpackage
`default_nettype wire

// File: rtl/egress_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : egress_arbiter_if                                      |
// | Description : FIFO-side pop bus and merged valid/ready output stream |
// |               of the egress arbiter.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface egress_arbiter_if #(
  parameter int BW = egress_arbiter_pkg::DEFAULT_BW
);
  logic          D0_empty;
  logic          D1_empty;
  logic          D0_error_output;
  logic          D1_error_output;
  logic [BW-1:0] D0_data_out;
  logic [BW-1:0] D1_data_out;
  logic          D0_rd;
  logic          D1_rd;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_src;

  // Arbiter side
  modport master (
    input  D0_empty, D1_empty, D0_error_output, D1_error_output,
    input  D0_data_out, D1_data_out, out_ready,
    output D0_rd, D1_rd, out_valid, out_data, out_src
  );

  // FIFO / link side
  modport slave (
    output D0_empty, D1_empty, D0_error_output, D1_error_output,
    output D0_data_out, D1_data_out, out_ready,
    input  D0_rd, D1_rd, out_valid, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/egress_arbiter_obuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : egress_obuf                                            |
// | Description : Tagged circular output buffer; head entry drives the   |
// |               output stream, push and pop may coincide.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module egress_obuf
  import egress_arbiter_pkg::*;
#(
  parameter int BW    = DEFAULT_BW,
  parameter int DEPTH = 2
) (
  input  wire logic                     clk,
  input  wire logic                     reset_L,
  input  wire logic                     push,
  input  wire logic [BW-1:0]            push_data,
  input  wire logic                     push_src,
  input  wire logic                     pop,
  output logic [$clog2(DEPTH):0]        occ,
  output logic [BW-1:0]                 head_data,
  output logic                          head_src
);
  localparam int AW = $clog2(DEPTH);

  logic [BW-1:0]  r_data [DEPTH];
  logic           r_src  [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_occ;
  logic           w_full;
  logic           w_pop_ok;
  logic           w_push_ok;

  assign w_full    = (r_occ == (AW+1)'(DEPTH));
  assign w_pop_ok  = pop & (r_occ != '0);
  assign w_push_ok = push & (~w_full | w_pop_ok);

  // Storage is cleared so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_src[i]  <= SRC_D0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push_ok) begin
        r_data[r_wptr] <= push_data;
        r_src[r_wptr]  <= push_src;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occ       = r_occ;
  assign head_data = r_data[r_rptr];
  assign head_src  = r_src[r_rptr];

endmodule
`default_nettype wire

// File: rtl/egress_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : egress_arbiter                                         |
// | Description : Weighted round-robin merge of the D0/D1 egress FIFOs   |
// |               into one buffered valid/ready stream. Define           |
// |               EGRESS_CNT_EN to build the delivered-word counters.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module egress_arbiter
  import egress_arbiter_pkg::*;
#(
  parameter int BW         = DEFAULT_BW,
  parameter int OBUF_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  wire logic          clk,
  input  wire logic          reset_L,
  egress_arbiter_if.master   bus,
  input  wire logic [3:0]    Peso_D0,
  input  wire logic [3:0]    Peso_D1,
  output logic               idle_arb,
  output logic [CNT_W-1:0]   cnt_D0,
  output logic [CNT_W-1:0]   cnt_D1
);
  localparam int OW = $clog2(OBUF_DEPTH) + 1;

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic           r_last;
  logic           r_inflight;
  logic           r_inflight_src;
  logic           r_idle;
  logic [3:0]     r_burst_cnt;
  logic [3:0]     w_burst_nxt;
  logic [3:0]     r_weight;
  logic [3:0]     w_weight_nxt;
  logic [3:0]     w_cnt_inc;
  logic           w_elig0;
  logic           w_elig1;
  logic           w_rd0;
  logic           w_rd1;
  logic           w_valid;
  logic           w_pop;
  logic           w_room;
  logic           w_idle_cond;
  logic [OW-1:0]  w_occ;
  logic [OW:0]    w_level;
  logic [BW-1:0]  w_push_data;
  logic [BW-1:0]  w_head_data;
  logic           w_head_src;

  assign w_elig0 = ~bus.D0_empty & ~bus.D0_error_output;
  assign w_elig1 = ~bus.D1_empty & ~bus.D1_error_output;
  assign w_valid = (w_occ != '0);
  assign w_pop   = w_valid & bus.out_ready;

  // A word issued now lands in the buffer next cycle, so reserve its slot.
  assign w_level = (OW+1)'(w_occ) + (OW+1)'(r_inflight) - (OW+1)'(w_pop);
  assign w_room  = (w_level < (OW+1)'(OBUF_DEPTH));

  always_comb begin
    w_state_nxt  = r_state;
    w_burst_nxt  = r_burst_cnt;
    w_weight_nxt = r_weight;
    w_rd0        = 1'b0;
    w_rd1        = 1'b0;
    w_cnt_inc    = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && (!w_elig1 || r_last == SRC_D1)) begin
          w_state_nxt  = ST_SERVE_D0;
          w_weight_nxt = eff_weight(Peso_D0);
          w_burst_nxt  = '0;
        end else if (w_elig1) begin
          w_state_nxt  = ST_SERVE_D1;
          w_weight_nxt = eff_weight(Peso_D1);
          w_burst_nxt  = '0;
        end
      end
      ST_SERVE_D0: begin
        w_rd0       = w_elig0 & w_room;
        w_cnt_inc   = r_burst_cnt + {3'b000, w_rd0};
        w_burst_nxt = w_cnt_inc;
        if (w_cnt_inc >= r_weight || !w_elig0) begin
          w_burst_nxt = '0;
          if (w_elig1) begin
            w_state_nxt  = ST_SERVE_D1;
            w_weight_nxt = eff_weight(Peso_D1);
          end else if (w_elig0) begin
            w_weight_nxt = eff_weight(Peso_D0);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_SERVE_D1: begin
        w_rd1       = w_elig1 & w_room;
        w_cnt_inc   = r_burst_cnt + {3'b000, w_rd1};
        w_burst_nxt = w_cnt_inc;
        if (w_cnt_inc >= r_weight || !w_elig1) begin
          w_burst_nxt = '0;
          if (w_elig0) begin
            w_state_nxt  = ST_SERVE_D0;
            w_weight_nxt = eff_weight(Peso_D0);
          end else if (w_elig1) begin
            w_weight_nxt = eff_weight(Peso_D1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_idle_cond = ~w_elig0 & ~w_elig1 & ~r_inflight &
                       (w_occ == '0) & (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state        <= ST_IDLE;
      r_last         <= SRC_D1;
      r_burst_cnt    <= '0;
      r_weight       <= 4'd1;
      r_inflight     <= 1'b0;
      r_inflight_src <= SRC_D0;
      r_idle         <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_weight    <= w_weight_nxt;
      if (w_rd0) begin
        r_last <= SRC_D0;
      end else if (w_rd1) begin
        r_last <= SRC_D1;
      end
      r_inflight     <= w_rd0 | w_rd1;
      r_inflight_src <= w_rd1 ? SRC_D1 : SRC_D0;
      r_idle         <= w_idle_cond;
    end
  end

  // FIFO read data is valid the cycle after rd; it goes straight into the buffer.
  assign w_push_data = (r_inflight_src == SRC_D1) ? bus.D1_data_out : bus.D0_data_out;

  egress_obuf #(
    .BW    (BW),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (r_inflight),
    .push_data (w_push_data),
    .push_src  (r_inflight_src),
    .pop       (w_pop),
    .occ       (w_occ),
    .head_data (w_head_data),
    .head_src  (w_head_src)
  );

  assign bus.D0_rd     = w_rd0;
  assign bus.D1_rd     = w_rd1;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_head_data;
  assign bus.out_src   = w_head_src;
  assign idle_arb      = r_idle;

`ifdef EGRESS_CNT_EN
  logic [CNT_W-1:0] r_cnt_d0;
  logic [CNT_W-1:0] r_cnt_d1;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt_d0 <= '0;
      r_cnt_d1 <= '0;
    end else if (w_pop) begin
      if (w_head_src == SRC_D1) begin
        r_cnt_d1 <= r_cnt_d1 + 1'b1;
      end else begin
        r_cnt_d0 <= r_cnt_d0 + 1'b1;
      end
    end
  end

  assign cnt_D0 = r_cnt_d0;
  assign cnt_D1 = r_cnt_d1;
`else
  assign cnt_D0 = '0;
  assign cnt_D1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_egress_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_egress_arbiter                                      |
// | Description : Self-checking bench for egress_arbiter with FIFO       |
// |               models, a delivery scoreboard and a turn-level WRR     |
// |               reference.                                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_egress_arbiter;
  import egress_arbiter_pkg::*;

  localparam int BW         = 6;
  localparam int OBUF_DEPTH = 2;
  localparam int CNT_W      = 4;

  logic             clk = 1'b0;
  logic             reset_L;
  logic [3:0]       Peso_D0;
  logic [3:0]       Peso_D1;
  logic             idle_arb;
  logic [CNT_W-1:0] cnt_D0;
  logic [CNT_W-1:0] cnt_D1;

  egress_arbiter_if #(.BW(BW)) bus ();

  egress_arbiter #(
    .BW         (BW),
    .OBUF_DEPTH (OBUF_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .bus      (bus),
    .Peso_D0  (Peso_D0),
    .Peso_D1  (Peso_D1),
    .idle_arb (idle_arb),
    .cnt_D0   (cnt_D0),
    .cnt_D1   (cnt_D1)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic [BW:0]   sb[$];
  logic          got_src[$];
  logic          exp_src[$];

  int  n_pass = 0;
  int  n_total = 0;
  int  cyc = 0;
  int  n_rd0, n_rd1, first_rd0, last_rd0;
  int  exp_cnt0, exp_cnt1;
  bit  ready_rand;
  bit  prev_hold;
  logic [BW-1:0] prev_data;
  logic          prev_src;
  logic          obs_rd0, obs_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_flags();
    bus.D0_empty = (q0.size() == 0);
    bus.D1_empty = (q1.size() == 0);
  endtask

  task automatic load(input int port, input int n);
    for (int i = 0; i < n; i++) begin
      if (port == 0) q0.push_back(BW'($urandom));
      else           q1.push_back(BW'($urandom));
    end
    update_flags();
  endtask

  // Observe the cycle at the falling edge, then commit FIFO pops after the rising edge.
  task automatic tick_obs();
    logic [BW:0] e;
    @(negedge clk);
    cyc++;
    obs_rd0 = bus.D0_rd;
    obs_rd1 = bus.D1_rd;
    if (prev_hold) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, prev_data);
      chk("hold_src", bus.out_src, prev_src);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_word", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e[BW-1:0]);
        chk("out_src", bus.out_src, e[BW]);
        got_src.push_back(bus.out_src);
        if (e[BW]) exp_cnt1++;
        else       exp_cnt0++;
      end
    end
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    prev_src  = bus.out_src;
    if (obs_rd0) begin
      chk("d0_rd_nonempty", bus.D0_empty, 0);
      chk("rd_onehot", bus.D1_rd, 0);
      n_rd0++;
      if (first_rd0 < 0) first_rd0 = cyc;
      last_rd0 = cyc;
      if (q0.size() > 0) sb.push_back({SRC_D0, q0[0]});
    end
    if (obs_rd1) begin
      chk("d1_rd_nonempty", bus.D1_empty, 0);
      n_rd1++;
      if (q1.size() > 0) sb.push_back({SRC_D1, q1[0]});
    end
  endtask

  task automatic tick_commit();
    @(posedge clk);
    #1;
    if (obs_rd0 && q0.size() > 0) bus.D0_data_out = q0.pop_front();
    if (obs_rd1 && q1.size() > 0) bus.D1_data_out = q1.pop_front();
    update_flags();
    if (ready_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick();
    tick_obs();
    tick_commit();
  endtask

  task automatic flush_model();
    q0.delete(); q1.delete(); sb.delete(); got_src.delete();
    exp_cnt0 = 0; exp_cnt1 = 0; prev_hold = 0;
    n_rd0 = 0; n_rd1 = 0; first_rd0 = -1; last_rd0 = -1;
    bus.D0_error_output = 1'b0;
    bus.D1_error_output = 1'b0;
    ready_rand = 1'b0;
    bus.out_ready = 1'b0;
    update_flags();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_d0_rd"}, bus.D0_rd, 0);
    chk({tag, "_d1_rd"}, bus.D1_rd, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_src"}, bus.out_src, 0);
    chk({tag, "_idle_arb"}, idle_arb, 1);
    chk({tag, "_cnt_d0"}, cnt_D0, 0);
    chk({tag, "_cnt_d1"}, cnt_D1, 0);
  endtask

  task automatic check_counters(input string tag);
`ifdef EGRESS_CNT_EN
    chk({tag, "_cnt_d0"}, cnt_D0, exp_cnt0 % (1 << CNT_W));
    chk({tag, "_cnt_d1"}, cnt_D1, exp_cnt1 % (1 << CNT_W));
`else
    chk({tag, "_cnt_d0"}, cnt_D0, 0);
    chk({tag, "_cnt_d1"}, cnt_D1, 0);
`endif
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_drain_in_time"}, (n < max_cyc), 1);
  endtask

  // Turn-level WRR reference: each turn takes min(weight, remaining) words; turns alternate.
  task automatic build_wrr(input int n0, input int n1, input int p0, input int p1);
    int r0 = n0;
    int r1 = n1;
    int w0 = (p0 == 0) ? 1 : p0;
    int w1 = (p1 == 0) ? 1 : p1;
    bit cur = 1'b0;
    exp_src.delete();
    while (r0 + r1 > 0) begin
      if (!cur) begin
        int k = (r0 < w0) ? r0 : w0;
        repeat (k) exp_src.push_back(SRC_D0);
        r0 -= k;
      end else begin
        int k = (r1 < w1) ? r1 : w1;
        repeat (k) exp_src.push_back(SRC_D1);
        r1 -= k;
      end
      cur = !cur;
    end
  endtask

  task automatic compare_wrr(input string tag);
    int n = (got_src.size() < exp_src.size()) ? got_src.size() : exp_src.size();
    chk({tag, "_wrr_len"}, got_src.size(), exp_src.size());
    for (int i = 0; i < n; i++) chk({tag, "_wrr_src"}, got_src[i], exp_src[i]);
  endtask

  initial begin
    int n0, n1, p0, p1, seen;
    reset_L = 1'b0;
    Peso_D0 = 4'd1;
    Peso_D1 = 4'd1;
    bus.D0_data_out = '0;
    bus.D1_data_out = '0;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    reset_L = 1'b1;
    tick();
    check_reset_vals("rst_release");

    // Weighted round robin 3:1 with both FIFOs full
    do_reset();
    Peso_D0 = 4'd3; Peso_D1 = 4'd1;
    bus.out_ready = 1'b1;
    load(0, 8); load(1, 8);
    drain("weights", 200);
    build_wrr(8, 8, 3, 1);
    compare_wrr("weights");
    check_counters("weights");

    // Backpressure: buffer fills, rd stops, output held
    do_reset();
    Peso_D1 = 4'd2;
    load(1, 5);
    repeat (10) tick();
    chk("bp_rd_count", n_rd1, OBUF_DEPTH);
    chk("bp_rd_stopped", obs_rd1, 0);
    chk("bp_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    drain("bp", 100);
    chk("bp_total_rd", n_rd1, 5);
    chk("bp_delivered", got_src.size(), 5);
    check_counters("bp");

    // Work-conserving single port
    do_reset();
    Peso_D0 = 4'd2;
    bus.out_ready = 1'b1;
    load(0, 6);
    drain("wc", 100);
    chk("wc_rd_count", n_rd0, 6);
    chk("wc_no_gap", last_rd0 - first_rd0, 5);
    repeat (3) tick();
    chk("wc_idle", idle_arb, 1);

    // Error flag masks D0
    do_reset();
    bus.D0_error_output = 1'b1;
    bus.out_ready = 1'b1;
    load(0, 4); load(1, 4);
    repeat (30) tick();
    chk("mask_d0_rd", n_rd0, 0);
    chk("mask_delivered", got_src.size(), 4);
    foreach (got_src[i]) chk("mask_src", got_src[i], SRC_D1);
    bus.D0_error_output = 1'b0;
    drain("mask", 100);
    chk("mask_after_release", got_src.size(), 8);
    check_counters("mask");

    // Counter wrap past 2^CNT_W
    do_reset();
    Peso_D0 = 4'd0;
    bus.out_ready = 1'b1;
    load(0, 17);
    drain("wrap", 200);
    check_counters("wrap");

    // Randomized weights, loads and backpressure
    for (int r = 0; r < 5; r++) begin
      do_reset();
      p0 = $urandom_range(0, 15); p1 = $urandom_range(0, 15);
      n0 = $urandom_range(0, 12); n1 = $urandom_range(0, 12);
      Peso_D0 = 4'(p0); Peso_D1 = 4'(p1);
      ready_rand = 1'b1;
      bus.out_ready = 1'b1;
      load(0, n0); load(1, n1);
      drain("rand", 400);
      build_wrr(n0, n1, p0, p1);
      compare_wrr("rand");
      check_counters("rand");
    end

    // Reset asserted during the second rd of a stream
    do_reset();
    Peso_D0 = 4'd3;
    bus.out_ready = 1'b1;
    load(0, 3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick_obs();
      if (n_rd0 == 2) begin
        seen = 1;
        break;
      end
      tick_commit();
    end
    chk("midrst_second_rd_seen", seen, 1);
    reset_L = 1'b0;
    #1;
    check_reset_vals("midrst");
    flush_model();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_word", bus.out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
